// File: rtl/color_scan_sched.sv
// Two-sensor colour scan scheduler: round-robin grant, filter settle, edge-count windows per colour.
// Optional macro COLOR_CLEAR_EN adds a clear-filter phase (select 2'b10) after blue and output cnt_c.
module color_scan_sched #(
    parameter int SETTLE_US = 100,
    parameter int WINDOW_US = 2000,
    parameter int CNT_W     = 10
) (
    input  logic             clkus,
    input  logic             rst_n,
    input  logic             req_object,
    input  logic             req_station,
    input  logic             object_wave,
    input  logic             station_wave,
    output logic [1:0]       object_select,
    output logic [1:0]       station_select,
    output logic             object_led,
    output logic             station_led,
    output logic [CNT_W-1:0] cnt_r,
    output logic [CNT_W-1:0] cnt_g,
    output logic [CNT_W-1:0] cnt_b,
`ifdef COLOR_CLEAR_EN
    output logic [CNT_W-1:0] cnt_c,
`endif
    output logic             result_src,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_COUNT   = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

`ifdef COLOR_CLEAR_EN
    localparam logic [1:0] LAST_COLOUR = 2'd3;
`else
    localparam logic [1:0] LAST_COLOUR = 2'd2;
`endif

    localparam int T_MAX = (SETTLE_US > WINDOW_US) ? SETTLE_US : WINDOW_US;
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_US - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_US - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;     // 0 = object, 1 = station
    logic             last_q, last_d;
    logic [1:0]       colour_q, colour_d;   // 0 R, 1 G, 2 B, 3 clear
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]       obj_sync_q, obj_sync_d;
    logic [2:0]       sta_sync_q, sta_sync_d;
    logic [CNT_W-1:0] shadow_r_q, shadow_r_d;
    logic [CNT_W-1:0] shadow_g_q, shadow_g_d;
    logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
    logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
`ifdef COLOR_CLEAR_EN
    logic [CNT_W-1:0] shadow_b_q, shadow_b_d;
    logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
`endif
    logic             result_src_q, result_src_d;
    logic             result_valid_q, result_valid_d;

    logic             obj_edge, sta_edge, wave_edge, granted_req, active;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       scan_select;

    // Bit 1 is the synchronized level; bit 2 is its previous value for rising-edge detection.
    assign obj_edge    = obj_sync_q[1] & ~obj_sync_q[2];
    assign sta_edge    = sta_sync_q[1] & ~sta_sync_q[2];
    assign wave_edge   = grant_q ? sta_edge : obj_edge;
    assign granted_req = grant_q ? req_station : req_object;
    assign cnt_inc     = (wave_edge && edge_cnt_q != CNT_MAX) ? edge_cnt_q + 1'b1 : edge_cnt_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        colour_d       = colour_q;
        timer_d        = timer_q;
        edge_cnt_d     = edge_cnt_q;
        obj_sync_d     = {obj_sync_q[1:0], object_wave};
        sta_sync_d     = {sta_sync_q[1:0], station_wave};
        shadow_r_d     = shadow_r_q;
        shadow_g_d     = shadow_g_q;
        cnt_r_d        = cnt_r_q;
        cnt_g_d        = cnt_g_q;
        cnt_b_d        = cnt_b_q;
`ifdef COLOR_CLEAR_EN
        shadow_b_d     = shadow_b_q;
        cnt_c_d        = cnt_c_q;
`endif
        result_src_d   = result_src_q;
        result_valid_d = result_valid_q;

        case (state_q)
            S_IDLE: begin
                if (req_object || req_station) begin
                    grant_d    = (req_object && req_station) ? ~last_q : req_station;
                    last_d     = grant_d;
                    colour_d   = 2'd0;
                    timer_d    = '0;
                    edge_cnt_d = '0;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                edge_cnt_d = '0;
                if (!granted_req) begin
                    state_d = S_IDLE;
                end else if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = S_COUNT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_COUNT: begin
                if (!granted_req) begin
                    // Aborted scans leave the published counts untouched.
                    edge_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (timer_q == WINDOW_LAST) begin
                    timer_d    = '0;
                    edge_cnt_d = '0;
                    case (colour_q)
                        2'd0:    shadow_r_d = cnt_inc;
                        2'd1:    shadow_g_d = cnt_inc;
`ifdef COLOR_CLEAR_EN
                        2'd2:    shadow_b_d = cnt_inc;
`endif
                        default: ;
                    endcase
                    if (colour_q == LAST_COLOUR) begin
                        cnt_r_d        = shadow_r_q;
                        cnt_g_d        = shadow_g_q;
`ifdef COLOR_CLEAR_EN
                        cnt_b_d        = shadow_b_q;
                        cnt_c_d        = cnt_inc;
`else
                        cnt_b_d        = cnt_inc;
`endif
                        result_src_d   = grant_q;
                        result_valid_d = 1'b1;
                        state_d        = S_PRESENT;
                    end else begin
                        colour_d = colour_q + 2'd1;
                        state_d  = S_SETTLE;
                    end
                end else begin
                    edge_cnt_d = cnt_inc;
                    timer_d    = timer_q + 1'b1;
                end
            end
            S_PRESENT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            grant_q        <= 1'b0;
            last_q         <= 1'b1;
            colour_q       <= 2'd0;
            timer_q        <= '0;
            edge_cnt_q     <= '0;
            obj_sync_q     <= '0;
            sta_sync_q     <= '0;
            shadow_r_q     <= '0;
            shadow_g_q     <= '0;
            cnt_r_q        <= '0;
            cnt_g_q        <= '0;
            cnt_b_q        <= '0;
`ifdef COLOR_CLEAR_EN
            shadow_b_q     <= '0;
            cnt_c_q        <= '0;
`endif
            result_src_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            colour_q       <= colour_d;
            timer_q        <= timer_d;
            edge_cnt_q     <= edge_cnt_d;
            obj_sync_q     <= obj_sync_d;
            sta_sync_q     <= sta_sync_d;
            shadow_r_q     <= shadow_r_d;
            shadow_g_q     <= shadow_g_d;
            cnt_r_q        <= cnt_r_d;
            cnt_g_q        <= cnt_g_d;
            cnt_b_q        <= cnt_b_d;
`ifdef COLOR_CLEAR_EN
            shadow_b_q     <= shadow_b_d;
            cnt_c_q        <= cnt_c_d;
`endif
            result_src_q   <= result_src_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        scan_select = 2'b11;
        case (colour_q)
            2'd0:    scan_select = 2'b00;
            2'd1:    scan_select = 2'b11;
            2'd2:    scan_select = 2'b01;
            default: scan_select = 2'b10;
        endcase
    end

    // Outputs decode from state flops, so reset reaches them without waiting for a clock.
    assign active         = (state_q != S_IDLE);
    assign busy           = active;
    assign object_led     = active && !grant_q;
    assign station_led    = active && grant_q;
    assign object_select  = object_led  ? scan_select : 2'b11;
    assign station_select = station_led ? scan_select : 2'b11;
    assign cnt_r          = cnt_r_q;
    assign cnt_g          = cnt_g_q;
    assign cnt_b          = cnt_b_q;
`ifdef COLOR_CLEAR_EN
    assign cnt_c          = cnt_c_q;
`endif
    assign result_src     = result_src_q;
    assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_color_scan_sched.sv
// Self-checking bench for color_scan_sched: periodic waves whose period divides the window give an
// alignment-free expected count (window/period, saturated); grants follow a round-robin model.
module tb_color_scan_sched;

    localparam int SETTLE = 4;
    localparam int WINDOW = 20;
    // A 20-cycle window holds at most 10 rising edges, so a 3-bit count is used to reach saturation.
    localparam int CW     = 3;
    localparam int CMAX   = (1 << CW) - 1;
`ifdef COLOR_CLEAR_EN
    localparam logic [7:0] EXP_SEQ = 8'b00_11_01_10;
    localparam int         NCOL    = 4;
`else
    localparam logic [7:0] EXP_SEQ = 8'b00_00_11_01;
    localparam int         NCOL    = 3;
`endif

    logic          clkus, rst_n;
    logic          req_object, req_station, object_wave, station_wave, result_ready;
    logic [1:0]    object_select, station_select;
    logic          object_led, station_led, result_src, result_valid, busy;
    logic [CW-1:0] cnt_r, cnt_g, cnt_b;
`ifdef COLOR_CLEAR_EN
    logic [CW-1:0] cnt_c;
`endif

    color_scan_sched #(.SETTLE_US(SETTLE), .WINDOW_US(WINDOW), .CNT_W(CW)) dut (
        .clkus(clkus), .rst_n(rst_n),
        .req_object(req_object), .req_station(req_station),
        .object_wave(object_wave), .station_wave(station_wave),
        .object_select(object_select), .station_select(station_select),
        .object_led(object_led), .station_led(station_led),
        .cnt_r(cnt_r), .cnt_g(cnt_g), .cnt_b(cnt_b),
`ifdef COLOR_CLEAR_EN
        .cnt_c(cnt_c),
`endif
        .result_src(result_src), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;
    int p_o = 4, h_o = 2, p_s = 5, h_s = 2;
    int ph_o = 0, ph_s = 0;
    bit last_srv;
    int prev_exp;
    int periods [5] = '{2, 4, 5, 10, 20};

    initial clkus = 1'b0;
    always #5 clkus = ~clkus;

    initial begin
        object_wave  = 1'b0;
        station_wave = 1'b0;
    end

    always @(negedge clkus) begin
        ph_o = (ph_o + 1) % p_o;
        ph_s = (ph_s + 1) % p_s;
        object_wave  = (ph_o < h_o);
        station_wave = (ph_s < h_s);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_count(input int p);
        return (WINDOW / p > CMAX) ? CMAX : WINDOW / p;
    endfunction

    function automatic bit pick(input bit ro, input bit rs);
        return (ro && rs) ? !last_srv : rs;
    endfunction

    task automatic set_waves(input int po, input int ho, input int ps, input int hs);
        p_o = po; h_o = ho; p_s = ps; h_s = hs;
        repeat (8) @(negedge clkus);
    endtask

    task automatic run_scan(input bit src, input int hold);
        logic [1:0] prev, sel;
        logic [7:0] seq;
        int nsel, exp;
        bit got, other_ok, stable_ok;
        exp = exp_count(src ? p_s : p_o);
        result_ready = (hold == 0);
        prev = 2'b11; seq = '0; nsel = 0; got = 0; other_ok = 1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clkus);
            sel = src ? station_select : object_select;
            if (src ? (object_select !== 2'b11 || object_led !== 1'b0)
                    : (station_select !== 2'b11 || station_led !== 1'b0)) other_ok = 0;
            if (sel !== prev) begin
                seq  = {seq[5:0], sel};
                nsel++;
                prev = sel;
            end
            if (result_valid === 1'b1) got = 1;
        end
        check("scan_done", got, 1);
        check("select_seq", seq, EXP_SEQ);
        check("select_changes", nsel, NCOL);
        check("ungranted_idle", other_ok, 1);
        check("led_on", src ? station_led : object_led, 1);
        check("result_src", result_src, src);
        check("cnt_r", cnt_r, exp);
        check("cnt_g", cnt_g, exp);
        check("cnt_b", cnt_b, exp);
`ifdef COLOR_CLEAR_EN
        check("cnt_c", cnt_c, exp);
`endif
        if (hold > 0) begin
            stable_ok = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clkus);
                if (result_valid !== 1'b1 || cnt_r !== CW'(exp) || cnt_g !== CW'(exp) ||
                    cnt_b !== CW'(exp) || result_src !== src) stable_ok = 0;
            end
            check("hold_stable", stable_ok, 1);
            result_ready = 1'b1;
        end
        @(negedge clkus);
        check("valid_cleared", result_valid, 0);
        check("led_off", src ? station_led : object_led, 0);
        check("busy_idle", busy, 0);
        last_srv = src;
        prev_exp = exp;
    endtask

    initial begin
        bit found;
        bit ro, rs;
        int r, hold, po, ps;
        rst_n = 1'b0; req_object = 1'b0; req_station = 1'b0; result_ready = 1'b1;
        last_srv = 1'b1; prev_exp = 0;
        repeat (3) @(negedge clkus);
        check("rst_obj_sel", object_select, 2'b11);
        check("rst_sta_sel", station_select, 2'b11);
        check("rst_leds", {object_led, station_led}, 2'b00);
        check("rst_cnts", {cnt_r, cnt_g, cnt_b}, 0);
        check("rst_valid", result_valid, 0);
        check("rst_src", result_src, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Both sensors requesting: object first after reset, then alternating.
        set_waves(4, 2, 5, 2);
        req_object = 1'b1; req_station = 1'b1;
        for (int k = 0; k < 3; k++) run_scan(pick(1, 1), 0);
        req_object = 1'b0; req_station = 1'b0;

        req_object = 1'b1;
        run_scan(pick(1, 0), 0);
        req_object = 1'b0;

        // Period-2 wave: 10 edges per window saturates the 3-bit count.
        set_waves(2, 1, 5, 2);
        req_object = 1'b1;
        run_scan(pick(1, 0), 0);
        req_object = 1'b0;

        set_waves(4, 1, 5, 3);
        req_object = 1'b1;
        run_scan(pick(1, 0), 10);
        req_object = 1'b0;

        req_station = 1'b1;
        run_scan(pick(0, 1), 0);
        req_station = 1'b0;

        // Abort the object scan in the third count cycle of green.
        req_object = 1'b1; req_station = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clkus);
            if (object_select === 2'b11 && object_led === 1'b1) found = 1;
        end
        check("green_reached", found, 1);
        repeat (SETTLE + 2) @(negedge clkus);
        req_object = 1'b0;
        @(negedge clkus);
        check("abort_led", object_led, 0);
        check("abort_sel", object_select, 2'b11);
        check("abort_valid", result_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cnts", {cnt_r, cnt_g, cnt_b}, {CW'(prev_exp), CW'(prev_exp), CW'(prev_exp)});
        last_srv = 1'b0;
        run_scan(pick(0, 1), 0);
        req_station = 1'b0;

        // Reset during the blue count window.
        req_object = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clkus);
            if (object_select === 2'b01) found = 1;
        end
        check("blue_reached", found, 1);
        repeat (SETTLE + 3) @(negedge clkus);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", {object_select, station_select}, 4'b1111);
        check("mid_rst_leds", {object_led, station_led}, 2'b00);
        check("mid_rst_cnts", {cnt_r, cnt_g, cnt_b}, 0);
        check("mid_rst_flags", {result_valid, result_src, busy}, 3'b000);
        @(negedge clkus);
        req_object = 1'b0; req_station = 1'b1;
        @(negedge clkus);
        rst_n = 1'b1;
        last_srv = 1'b1;
        run_scan(pick(0, 1), 0);
        req_station = 1'b0;

        // Randomized wave shapes, request patterns and ready stalls.
        for (int it = 0; it < 8; it++) begin
            po = periods[$urandom_range(0, 4)];
            ps = periods[$urandom_range(0, 4)];
            set_waves(po, $urandom_range(1, po - 1), ps, $urandom_range(1, ps - 1));
            r    = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            ro   = (r != 1);
            rs   = (r != 0);
            req_object = ro; req_station = rs;
            run_scan(pick(ro, rs), hold);
            if (ro && rs) run_scan(pick(1, 1), 0);
            req_object = 1'b0; req_station = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
